// File: rtl/rgb2gray_frame_ctrl.sv
// rgb2gray_frame_ctrl: feeds an external rgb2gray converter and tags its results
// with x/y/frame coordinates, counting a job of NUM_FRAMES frames.
module rgb2gray_frame_ctrl #(
  parameter int H_ACTIVE      = 1280,
  parameter int V_ACTIVE      = 720,
  parameter int NUM_FRAMES    = 143,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        src_valid,
  input  logic [7:0]  src_red,
  input  logic [7:0]  src_green,
  input  logic [7:0]  src_blue,
  output logic        src_ready,
  output logic [7:0]  cv_red,
  output logic [7:0]  cv_green,
  output logic [7:0]  cv_blue,
  output logic        cv_valid_in,
  input  logic [7:0]  cv_gray,
  input  logic        cv_valid_out,
  output logic [7:0]  pix_gray,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  frame_idx,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [10:0] XL = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  YL = 10'(V_ACTIVE - 1);
  localparam logic [7:0]  FL = 8'(NUM_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [10:0] in_x, out_x;
  logic [9:0] in_y, out_y;
  logic [7:0] in_f, out_f;
  logic [TW-1:0] quiet;
  logic out_full, xfer, go, acc, in_last, out_last, timeout;
  always_comb begin
    xfer     = src_valid && src_ready;
    go       = start && state == IDLE;
    acc      = cv_valid_out && (state == RUN || state == DRAIN) && !out_full;
    in_last  = in_x == XL && in_y == YL && in_f == FL;
    out_last = out_x == XL && out_y == YL && out_f == FL;
    timeout  = state == DRAIN && !cv_valid_out && quiet == TW'(DRAIN_TIMEOUT - 1);
  end
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = xfer && in_last ? DRAIN : RUN;
      DRAIN:   state_nx = out_full || (acc && out_last) || timeout ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    src_ready = state == RUN;
    busy      = state == RUN || state == DRAIN;
    done      = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      {in_x, in_y, in_f, out_x, out_y, out_f} <= '0;
      {cv_red, cv_green, cv_blue, cv_valid_in} <= '0;
      {pix_gray, pix_x, pix_y, frame_idx, pix_valid} <= '0;
      {pix_sof, pix_eol, pix_eof, err, out_full} <= '0;
      quiet <= '0;
    end else begin
      cv_valid_in <= xfer;
      if (xfer) {cv_red, cv_green, cv_blue} <= {src_red, src_green, src_blue};
      if (go) {in_x, in_y, in_f} <= '0;
      else if (xfer) begin
        in_x <= in_x == XL ? '0 : in_x + 1'b1;
        if (in_x == XL) begin
          in_y <= in_y == YL ? '0 : in_y + 1'b1;
          if (in_y == YL) in_f <= in_f + 1'b1;
        end
      end
      if (go) {out_x, out_y, out_f} <= '0;
      else if (acc) begin
        out_x <= out_x == XL ? '0 : out_x + 1'b1;
        if (out_x == XL) begin
          out_y <= out_y == YL ? '0 : out_y + 1'b1;
          if (out_y == YL) out_f <= out_f + 1'b1;
        end
      end
      out_full  <= !go && (out_full || (acc && out_last));
      pix_valid <= acc;
      pix_sof   <= acc && out_x == '0 && out_y == '0;
      pix_eol   <= acc && out_x == XL;
      pix_eof   <= acc && out_x == XL && out_y == YL;
      if (acc) {pix_gray, pix_x, pix_y, frame_idx} <= {cv_gray, out_x, out_y, out_f};
      // any converter result that cannot be tagged is dropped and flagged
      quiet <= state == DRAIN && !cv_valid_out ? quiet + 1'b1 : '0;
      err   <= (err && !go) || (cv_valid_out && !acc) || timeout;
    end
  end
endmodule
